// File: rtl/rtl_divide_pkg.sv
// Shared definitions for the sequential divider and its sibling multiplier FSM.
// Holds the common state encoding and the iteration counter sizing rule.
package rtl_divide_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Wide enough to hold the full 2*width iteration count itself.
   function automatic int cnt_width(input int width);
      return $clog2(2 * width + 1);
   endfunction

endpackage

// File: rtl/rtl_divide_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if it fits and report the resulting quotient bit.
module div_step
   import rtl_divide_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   prem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   prem_o,
   output logic             q_bit_o
);

   logic [WIDTH+1:0] ext;
   logic [WIDTH:0]   trial;

   // The partial remainder stays below the divisor, so a successful
   // subtraction always fits back into WIDTH+1 bits.
   always_comb begin
      ext     = {prem_i, bit_i};
      trial   = ext[WIDTH:0] - {1'b0, divisor_i};
      q_bit_o = (ext >= {2'b00, divisor_i});
      prem_o  = q_bit_o ? trial : ext[WIDTH:0];
   end

endmodule

// File: rtl/rtl_divide.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake matching the multiplier.
module rtl_divide
   import rtl_divide_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               done,
   output logic               busy,
   output logic               div_by_zero
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(2 * WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e               state_q, state_d;
   logic [2*WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH:0]       prem_q, prem_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 dbz_q, dbz_d;
   logic                 accept;
   logic                 zero_div;
   logic [WIDTH:0]       step_rem;
   logic                 step_bit;

   div_step #(
      .WIDTH(WIDTH)
   ) u_div_step (
      .prem_i    (prem_q),
      .bit_i     (sr_q[2*WIDTH-1]),
      .divisor_i (dvs_q),
      .prem_o    (step_rem),
      .q_bit_o   (step_bit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         dbz_q   <= dbz_d;
      end
   end

   // The first DONE cycle latches the result; start is only taken once done is up.
   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      dvs_d    = dvs_q;
      prem_d   = prem_q;
      cnt_d    = cnt_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      done_d   = done_q;
      busy_d   = busy_q;
      dbz_d    = dbz_q;
      accept   = 1'b0;
      zero_div = (dvs_q == '0);

      case (state_q)
         IDLE: accept = start;
         CALC: begin
            prem_d = step_rem;
            sr_d   = {sr_q[2*WIDTH-2:0], step_bit};
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!done_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               dbz_d  = zero_div;
               quot_d = zero_div ? '1 : sr_q;
               rem_d  = zero_div ? sr_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
            end else begin
               accept = start;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         sr_d    = dividend;
         dvs_d   = divisor;
         prem_d  = '0;
         cnt_d   = CNT_LOAD;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
         state_d = (divisor == '0) ? DONE : CALC;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_rtl_divide.sv
// Scoreboard bench for rtl_divide at WIDTH=4: expected results are queued
// when a division is launched and compared when done rises.
module tb_rtl_divide;

   localparam int WIDTH = 4;

   logic               clk;
   logic               reset_n;
   logic               start;
   logic [2*WIDTH-1:0] dividend;
   logic [WIDTH-1:0]   divisor;
   logic [2*WIDTH-1:0] quotient;
   logic [WIDTH-1:0]   remainder;
   logic               done;
   logic               busy;
   logic               div_by_zero;

   typedef struct {
      logic [2*WIDTH-1:0] dvd;
      logic [WIDTH-1:0]   dvs;
      logic [2*WIDTH-1:0] q;
      logic [WIDTH-1:0]   r;
      logic               dbz;
      int                 lat;
   } exp_t;

   exp_t expQueue[$];
   int   assertCount = 0;
   int   failCount   = 0;

   rtl_divide #(
      .WIDTH(WIDTH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .done        (done),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Launch a division from a negedge; returns at the negedge after acceptance.
   task automatic applyStimulus(input logic [2*WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
      exp_t e;
      e.dvd = dvd;
      e.dvs = dvs;
      if (dvs == 0) begin
         e.q   = '1;
         e.r   = dvd[WIDTH-1:0];
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
         e.q   = dvd / dvs;
         e.r   = WIDTH'(dvd % dvs);
         e.dbz = 1'b0;
         e.lat = 2 * WIDTH + 1;
      end
      expQueue.push_back(e);
      start    = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      nextCycle();
      start = 1'b0;
      checkOutput("done_after_accept", {31'd0, done}, 32'd0);
      checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   // Wait (bounded) for done, then compare against the oldest queued result.
   task automatic waitResult(input int spent);
      exp_t e;
      int   cycles = 0;
      while (!done && cycles < 50) begin
         nextCycle();
         cycles++;
      end
      checkOutput("sb_size", expQueue.size(), 32'd1);
      if (expQueue.size() > 0) begin
         e = expQueue.pop_front();
         checkOutput("latency", cycles + spent, e.lat);
         checkOutput("quotient", {24'd0, quotient}, {24'd0, e.q});
         checkOutput("remainder", {28'd0, remainder}, {28'd0, e.r});
         checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
         checkOutput("busy_done", {31'd0, busy}, 32'd0);
         if (!e.dbz) begin
            checkOutput("invariant", quotient * e.dvs + remainder, {24'd0, e.dvd});
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_quotient"}, {24'd0, quotient}, 32'd0);
      checkOutput({tag, "_remainder"}, {28'd0, remainder}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkAllZero("reset");

      applyStimulus(8'd12, 4'd3);
      waitResult(0);
      applyStimulus(8'd63, 4'd9);
      waitResult(0);
      applyStimulus(8'd200, 4'd7);
      waitResult(0);
      applyStimulus(8'd255, 4'd1);
      waitResult(0);
      applyStimulus(8'h5A, 4'd0);
      waitResult(0);

      // A start pulse during CALC must be ignored.
      applyStimulus(8'd12, 4'd3);
      nextCycle();
      nextCycle();
      start    = 1'b1;
      dividend = 8'd9;
      divisor  = 4'd3;
      nextCycle();
      start = 1'b0;
      checkOutput("busy_calc", {31'd0, busy}, 32'd1);
      waitResult(3);

      // Restart straight from DONE.
      applyStimulus(8'd9, 4'd3);
      waitResult(0);

      // Asynchronous abort mid-CALC.
      applyStimulus(8'd63, 4'd9);
      nextCycle();
      nextCycle();
      #2 reset_n = 1'b0;
      #1 checkAllZero("async_reset");
      if (expQueue.size() > 0) void'(expQueue.pop_back());
      nextCycle();
      reset_n = 1'b1;
      nextCycle();
      checkAllZero("post_reset");

      applyStimulus(8'd10, 4'd4);
      waitResult(0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/rtl_divide.md
Name: rtl_divide

Overview:
- Sequential restoring divider. It is the inverse companion of the shift-add RTL multiplier, with the same start/done handshake style.
- Takes a 2*WIDTH-bit dividend and a WIDTH-bit divisor, and returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Resolves one quotient bit per clock.
- Used by lab datapaths to undo or check multiplier results, e.g. product / multiplicand = multiplier.

Parameters:
- WIDTH, default 4: divisor and remainder width. Dividend and quotient are 2*WIDTH bits.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: request to begin a division. Sampled on clk rising edge.
- dividend, input, 2*WIDTH: numerator. Captured when start is accepted.
- divisor, input, WIDTH: denominator. Captured when start is accepted.
- quotient, output, 2*WIDTH: result quotient. Registered.
- remainder, output, WIDTH: result remainder. Registered.
- done, output, 1: result valid. Held high until the next accepted start.
- busy, output, 1: high while a division is in progress.
- div_by_zero, output, 1: set together with done when the captured divisor was 0.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - reset_n=0 immediately forces state=IDLE and clears quotient, remainder, done, busy, div_by_zero and all internal registers to 0.
  - Reset mid-operation aborts the division with no partial result kept.
- State machine has three states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at a rising edge is accepted: capture dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits), load iteration counter = 2*WIDTH, set busy=1, clear done and div_by_zero.
  - If captured divisor==0, go to DONE; otherwise go to CALC.
- CALC, each cycle:
  - Shift {partial_rem, dividend_sr} left by 1.
  - trial = shifted partial_rem - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: partial_rem=trial and the new quotient LSB = 1.
  - Otherwise: keep the shifted partial_rem and the new quotient LSB = 0.
  - Decrement the counter. The cycle that consumes the last step (counter 1->0) transitions to DONE.
- DONE:
  - busy=0, done=1.
  - quotient = final shift register; remainder = partial_rem[WIDTH-1:0].
  - Outputs hold until the next accepted start.
  - start=1 in DONE is accepted exactly as in IDLE: done drops the cycle after acceptance.
- Latency:
  - Start accepted at edge N gives done=1 after edge N+2*WIDTH+1 (9 cycles for WIDTH=4).
  - Divide-by-zero: done=1 after edge N+1.
- Divide-by-zero result: quotient = all ones, remainder = dividend[WIDTH-1:0], div_by_zero=1.
- start while busy (in CALC) is ignored. dividend and divisor may change freely after acceptance.
- Invariant on a normal result: quotient*divisor + remainder == dividend, and remainder < divisor.
- Arithmetic is unsigned only. No overflow is possible, since quotient is 2*WIDTH bits wide.
- start held high continuously: a new division restarts each time DONE is reached. This is legal.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the counter width derivation $clog2(2*WIDTH+1).
- The package is reusable by the multiplier FSM.
- One natural sub-module, div_step: the combinational shift-subtract-compare.
  - Inputs: partial_rem, next dividend bit, divisor.
  - Outputs: new partial_rem, quotient bit.
- Everything else stays in rtl_divide.

Test Plan:
- Reset then start with dividend=12, divisor=3 -> after 9 cycles done=1, quotient=4, remainder=0, div_by_zero=0, busy low.
- dividend=63, divisor=9 -> quotient=7, remainder=0. Inverts the multiplier vector 7*9.
- dividend=200, divisor=7 -> quotient=28, remainder=4. Then dividend=255, divisor=1 -> quotient=255, remainder=0.
- divisor=0, dividend=0x5A -> done one cycle after acceptance, div_by_zero=1, quotient=0xFF, remainder=0xA.
- Start 12/3, pulse start again with 9/3 during CALC -> ignored, result still 4 r0. Then start 9/3 in DONE -> done falls next cycle, result 3 r0.
- Start 63/9, assert reset_n=0 asynchronously mid-CALC (between edges) -> all outputs 0 immediately. After release, a new start with 10/4 -> quotient=2, remainder=2.
